// File: rtl/gpio_wb_pkg.sv
// Shared constants for the GPIO Wishbone slave: register offsets, bus FSM states
// and the window alignment width.
package gpio_wb_pkg;

    localparam int WIN_LSB = 5;   // address bits below this select within the 32-byte window

    localparam logic [2:0] REG_OUT   = 3'd0;
    localparam logic [2:0] REG_IN    = 3'd1;
    localparam logic [2:0] REG_DIR   = 3'd2;
    localparam logic [2:0] REG_IEN   = 3'd3;
    localparam logic [2:0] REG_ISTAT = 3'd4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; 2-cycle latency, no backpressure.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/gpio_wb.sv
// GPIO block behind a Wishbone classic slave with rising-edge interrupts.
// Every hit acks one cycle later for exactly one cycle; no wait states, no stalls.
module gpio_wb
    import gpio_wb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0800,
    parameter int          NCH       = 8
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic [31:0]    dat_i,
    output logic [31:0]    dat_o,
    input  logic [31:0]    adr_i,
    input  logic           we_i,
    input  logic [3:0]     sel_i,
    input  logic           cyc_i,
    input  logic           stb_i,
    output logic           ack_o,
    input  logic [NCH-1:0] gpio_i,
    output logic [NCH-1:0] gpio_o,
    output logic [NCH-1:0] gpio_oe_o,
    output logic           irq_o
);

    state_t           state_q;
    logic             ack_q;
    logic             irq_q;
    logic [31:0]      dat_q;
    logic [NCH-1:0]   out_q,   out_d;
    logic [NCH-1:0]   dir_q,   dir_d;
    logic [NCH-1:0]   ien_q,   ien_d;
    logic [NCH-1:0]   istat_q, istat_d;
    logic [NCH-1:0]   prev_q;
    logic [NCH-1:0]   in_sync;
    logic [NCH-1:0]   rise;
    logic [NCH-1:0]   wm;
    logic [NCH-1:0]   wd;
    logic [NCH-1:0]   clr;
    logic [31:0]      lane_m;
    logic [31:0]      rdata;
    logic [2:0]       reg_sel;
    logic             hit;
    logic             take;
    logic             wr_en;
    logic             unused_bits;

    sync_2ff #(.WIDTH(NCH)) u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (gpio_i),
        .q_o    (in_sync)
    );

    assign hit     = cyc_i & stb_i & (adr_i[31:WIN_LSB] == BASE_ADDR[31:WIN_LSB]);
    assign take    = hit & (state_q == ST_IDLE);
    assign wr_en   = take & we_i;
    assign reg_sel = adr_i[4:2];
    assign lane_m  = lane_mask(sel_i);
    assign wm      = lane_m[NCH-1:0];
    assign wd      = dat_i[NCH-1:0];
    assign rise    = in_sync & ~prev_q & ien_q;

    assign unused_bits = ^{adr_i[1:0], dat_i, lane_m};

    // A rising edge in the same cycle as a W1C keeps the status bit set.
    always_comb begin
        out_d   = out_q;
        dir_d   = dir_q;
        ien_d   = ien_q;
        clr     = '0;
        if (wr_en) begin
            case (reg_sel)
                REG_OUT:   out_d = (out_q & ~wm) | (wd & wm);
                REG_DIR:   dir_d = (dir_q & ~wm) | (wd & wm);
                REG_IEN:   ien_d = (ien_q & ~wm) | (wd & wm);
                REG_ISTAT: clr   = wd & wm;
                default:   clr   = '0;
            endcase
        end
        istat_d = (istat_q & ~clr) | rise;
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_OUT:   rdata[NCH-1:0] = out_q;
            REG_IN:    rdata[NCH-1:0] = in_sync;
            REG_DIR:   rdata[NCH-1:0] = dir_q;
            REG_IEN:   rdata[NCH-1:0] = ien_q;
            REG_ISTAT: rdata[NCH-1:0] = istat_q;
            default:   rdata          = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (hit) begin
                        state_q <= ST_ACK;
                        ack_q   <= 1'b1;
                        if (!we_i) dat_q <= rdata;
                    end
                end
                ST_ACK: begin
                    state_q <= ST_IDLE;
                    ack_q   <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_q   <= '0;
            dir_q   <= '0;
            ien_q   <= '0;
            istat_q <= '0;
            prev_q  <= '0;
            irq_q   <= 1'b0;
        end else begin
            out_q   <= out_d;
            dir_q   <= dir_d;
            ien_q   <= ien_d;
            istat_q <= istat_d;
            prev_q  <= in_sync;
            irq_q   <= |(istat_q & ien_q);
        end
    end

    assign dat_o     = dat_q;
    assign ack_o     = ack_q;
    assign irq_o     = irq_q;
    assign gpio_o    = out_q;
    assign gpio_oe_o = dir_q;

endmodule

// File: tb/tb_gpio_wb.sv
// Directed bench for gpio_wb with a read-data scoreboard checked on every ack.
module tb_gpio_wb;

    localparam logic [31:0] BASE = 32'h0000_0800;
    localparam int          NCH  = 8;

    logic           clk_i = 1'b0;
    logic           rst_ni = 1'b0;
    logic [31:0]    dat_i = '0;
    logic [31:0]    dat_o;
    logic [31:0]    adr_i = '0;
    logic           we_i = 1'b0;
    logic [3:0]     sel_i = '0;
    logic           cyc_i = 1'b0;
    logic           stb_i = 1'b0;
    logic           ack_o;
    logic [NCH-1:0] gpio_i = '0;
    logic [NCH-1:0] gpio_o;
    logic [NCH-1:0] gpio_oe_o;
    logic           irq_o;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        rd;
        logic [31:0] dat;
    } exp_t;
    exp_t sb[$];

    gpio_wb #(.BASE_ADDR(BASE), .NCH(NCH)) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .dat_i     (dat_i),
        .dat_o     (dat_o),
        .adr_i     (adr_i),
        .we_i      (we_i),
        .sel_i     (sel_i),
        .cyc_i     (cyc_i),
        .stb_i     (stb_i),
        .ack_o     (ack_o),
        .gpio_i    (gpio_i),
        .gpio_o    (gpio_o),
        .gpio_oe_o (gpio_oe_o),
        .irq_o     (irq_o)
    );

    always #5 clk_i = ~clk_i;

    // Scoreboard: every ack consumes one expected entry; reads compare dat_o.
    always @(posedge clk_i) begin
        #1;
        if (ack_o) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_unexpected_ack: ack_o=1 with nothing outstanding at %0t", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.rd) begin
                    n_cmp++;
                    if (dat_o !== e.dat) begin
                        n_err++;
                        $display("FAIL sb_read_data: got %h, want %h at %0t", dat_o, e.dat, $time);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Called 1 ns after a rising edge; returns 1 ns after the edge that drops ack.
    task automatic xfer(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                        input logic [31:0] wdat, input logic [31:0] exp_rd,
                        input logic expect_ack, output int cyc);
        exp_t e;
        e.rd  = !we;
        e.dat = exp_rd;
        if (expect_ack) sb.push_back(e);
        adr_i = adr; we_i = we; sel_i = sel; dat_i = wdat;
        cyc_i = 1'b1; stb_i = 1'b1;
        cyc = -1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (ack_o) begin
                cyc = i;
                break;
            end
        end
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; sel_i = '0;
        tick();
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if ({gpio_o, gpio_oe_o, ack_o, irq_o, dat_o} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: gpio_o=%h oe=%h ack=%b irq=%b dat_o=%h, want all 0",
                     gpio_o, gpio_oe_o, ack_o, irq_o, dat_o);
        end
        rst_ni = 1'b1;
    endtask

    task automatic test_out();
        int c;
        xfer(BASE + 32'h0, 1'b1, 4'b0001, 32'h1234_565A, '0, 1'b1, c);
        n_cmp++;
        if (c !== 1) begin n_err++; $display("FAIL out_ack_latency: got %0d cycles, want 1", c); end
        n_cmp++;
        if (ack_o !== 1'b0) begin n_err++; $display("FAIL out_ack_width: ack_o=%b, want 0", ack_o); end
        n_cmp++;
        if (gpio_o !== 8'h5A) begin n_err++; $display("FAIL out_gpio_o: got %h, want 5a", gpio_o); end
        xfer(BASE + 32'h0, 1'b1, 4'b0010, 32'h0000_FF00, '0, 1'b1, c);
        n_cmp++;
        if (gpio_o !== 8'h5A) begin n_err++; $display("FAIL out_lane_above_nch: got %h, want 5a", gpio_o); end
        xfer(BASE + 32'h0, 1'b0, 4'b1111, '0, 32'h0000_005A, 1'b1, c);
    endtask

    task automatic test_dir();
        int c;
        xfer(BASE + 32'h8, 1'b1, 4'b1111, 32'hFFFF_FFFF, '0, 1'b1, c);
        n_cmp++;
        if (gpio_oe_o !== 8'hFF) begin n_err++; $display("FAIL dir_oe: got %h, want ff", gpio_oe_o); end
        xfer(BASE + 32'h8, 1'b0, 4'b1111, '0, 32'h0000_00FF, 1'b1, c);
        xfer(BASE + 32'h8, 1'b1, 4'b0000, 32'h0000_0000, '0, 1'b1, c);
        n_cmp++;
        if (gpio_oe_o !== 8'hFF) begin n_err++; $display("FAIL dir_sel0: got %h, want ff", gpio_oe_o); end
        xfer(BASE + 32'h8, 1'b0, 4'b1111, '0, 32'h0000_00FF, 1'b1, c);
    endtask

    task automatic test_irq();
        int c;
        xfer(BASE + 32'hC, 1'b1, 4'b0001, 32'h0000_0001, '0, 1'b1, c);
        gpio_i[0] = 1'b1;
        // Sampled one edge later: synchronizer second stage still 0.
        xfer(BASE + 32'h4, 1'b0, 4'b1111, '0, 32'h0000_0000, 1'b1, c);
        xfer(BASE + 32'h4, 1'b0, 4'b1111, '0, 32'h0000_0001, 1'b1, c);
        n_cmp++;
        if (irq_o !== 1'b1) begin n_err++; $display("FAIL irq_set: irq_o=%b, want 1", irq_o); end
        xfer(BASE + 32'h10, 1'b0, 4'b1111, '0, 32'h0000_0001, 1'b1, c);
        xfer(BASE + 32'h10, 1'b1, 4'b0001, 32'h0000_0001, '0, 1'b1, c);
        n_cmp++;
        if (irq_o !== 1'b0) begin n_err++; $display("FAIL irq_w1c: irq_o=%b, want 0", irq_o); end
        xfer(BASE + 32'h10, 1'b0, 4'b1111, '0, 32'h0000_0000, 1'b1, c);
    endtask

    task automatic test_ien_clear();
        int c;
        xfer(BASE + 32'hC, 1'b1, 4'b0001, 32'h0000_0002, '0, 1'b1, c);
        gpio_i[1] = 1'b1;
        repeat (4) tick();
        n_cmp++;
        if (irq_o !== 1'b1) begin n_err++; $display("FAIL ien_irq: irq_o=%b, want 1", irq_o); end
        xfer(BASE + 32'hC, 1'b1, 4'b0001, 32'h0000_0000, '0, 1'b1, c);
        tick();
        n_cmp++;
        if (irq_o !== 1'b0) begin n_err++; $display("FAIL ien_mask_irq: irq_o=%b, want 0", irq_o); end
        xfer(BASE + 32'h10, 1'b0, 4'b1111, '0, 32'h0000_0002, 1'b1, c);
        gpio_i[2] = 1'b1;
        repeat (4) tick();
        xfer(BASE + 32'h10, 1'b0, 4'b1111, '0, 32'h0000_0002, 1'b1, c);
    endtask

    task automatic test_w1c_race();
        int c;
        xfer(BASE + 32'h10, 1'b1, 4'b0001, 32'h0000_00FF, '0, 1'b1, c);
        xfer(BASE + 32'hC, 1'b1, 4'b0001, 32'h0000_0001, '0, 1'b1, c);
        gpio_i = '0;
        repeat (3) tick();
        gpio_i[0] = 1'b1;
        repeat (2) tick();
        // W1C sampled on the same edge that registers the rising edge.
        xfer(BASE + 32'h10, 1'b1, 4'b0001, 32'h0000_0001, '0, 1'b1, c);
        xfer(BASE + 32'h10, 1'b0, 4'b1111, '0, 32'h0000_0001, 1'b1, c);
        xfer(BASE + 32'h10, 1'b1, 4'b0001, 32'h0000_0001, '0, 1'b1, c);
        xfer(BASE + 32'h10, 1'b0, 4'b1111, '0, 32'h0000_0000, 1'b1, c);
    endtask

    task automatic test_addr();
        int c;
        xfer(BASE + 32'h40, 1'b1, 4'b1111, 32'h0000_0000, '0, 1'b0, c);
        n_cmp++;
        if (c !== -1) begin n_err++; $display("FAIL miss_no_ack: ack after %0d cycles, want none", c); end
        n_cmp++;
        if (gpio_o !== 8'h5A) begin n_err++; $display("FAIL miss_no_write: gpio_o=%h, want 5a", gpio_o); end
        xfer(BASE + 32'h14, 1'b1, 4'b1111, 32'hFFFF_FFFF, '0, 1'b1, c);
        n_cmp++;
        if (c !== 1) begin n_err++; $display("FAIL unmapped_ack: got %0d cycles, want 1", c); end
        xfer(BASE + 32'h14, 1'b0, 4'b1111, '0, 32'h0000_0000, 1'b1, c);
    endtask

    task automatic test_reset_in_ack();
        int c;
        exp_t e;
        gpio_i = '0;
        repeat (3) tick();
        e.rd = 1'b0; e.dat = '0;
        sb.push_back(e);
        adr_i = BASE; we_i = 1'b1; sel_i = 4'b0001; dat_i = 32'h0000_00A5;
        cyc_i = 1'b1; stb_i = 1'b1;
        tick();
        n_cmp++;
        if (ack_o !== 1'b1) begin n_err++; $display("FAIL rst_ack_pre: ack_o=%b, want 1", ack_o); end
        #1 rst_ni = 1'b0;
        #1;
        n_cmp++;
        if ({ack_o, gpio_o, gpio_oe_o, irq_o, dat_o} !== '0) begin
            n_err++;
            $display("FAIL rst_in_ack: ack=%b gpio_o=%h oe=%h irq=%b dat_o=%h, want all 0",
                     ack_o, gpio_o, gpio_oe_o, irq_o, dat_o);
        end
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        tick();
        rst_ni = 1'b1;
        xfer(BASE + 32'h0, 1'b0, 4'b1111, '0, 32'h0000_0000, 1'b1, c);
        n_cmp++;
        if (c !== 1) begin n_err++; $display("FAIL rst_next_access: got %0d cycles, want 1", c); end
        xfer(BASE + 32'hC, 1'b0, 4'b1111, '0, 32'h0000_0000, 1'b1, c);
        xfer(BASE + 32'h10, 1'b0, 4'b1111, '0, 32'h0000_0000, 1'b1, c);
    endtask

    initial begin
        tick();
        test_reset();
        test_out();
        test_dir();
        test_irq();
        test_ien_clear();
        test_w1c_race();
        test_addr();
        test_reset_in_ack();
        repeat (2) tick();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: %0d entries left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
